// File: rtl/stream_link_pkg.sv
// Shared types and constants for the stream_link FIFO: overflow policy,
// drop-counter sizing and the occupancy-width helper.
package stream_link_pkg;

   typedef enum logic {
      BACKPRESSURE = 1'b0,
      DROP_NEWEST  = 1'b1
   } drop_mode_e;

   localparam int unsigned DROP_CNT_W = 8;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

   // Occupancy runs 0..depth inclusive, so it needs one more code than depth.
   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/stream_link_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset.
module stream_link_mem #(
   parameter  int unsigned WIDTH = 3,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/stream_link_fifo.sv
// First-word-fall-through link buffer between a tx producer and an rx consumer,
// with valid/ready on both sides and a backpressure or drop-newest overflow policy.
module stream_link_fifo
   import stream_link_pkg::*;
#(
   parameter int unsigned WIDTH     = 3,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned DROP_MODE = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   input  logic [WIDTH-1:0]            tx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic [WIDTH-1:0]            rx_data,
   output logic [level_w(DEPTH)-1:0]   level,
   output logic [DROP_CNT_W-1:0]       drop_cnt
);

   localparam drop_mode_e      MODE     = (DROP_MODE != 0) ? DROP_NEWEST : BACKPRESSURE;
   localparam int unsigned     AW       = $clog2(DEPTH);
   localparam int unsigned     LW       = level_w(DEPTH);
   localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [LW-1:0]         r_level;
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_drop;
   logic [WIDTH-1:0]      w_rdata;

   // tx_ready looks only at level and reset, so no path runs from tx_valid/rx_ready.
   // In drop-newest mode a full buffer still takes a word when a pop frees a slot.
   always_comb begin
      w_full   = (r_level == FULL_LVL);
      tx_ready = rst_n && ((MODE == DROP_NEWEST) || !w_full);
      rx_valid = (r_level != '0);
      w_pop    = rx_valid && rx_ready;
      w_push   = tx_valid && tx_ready && (!w_full || w_pop);
      w_drop   = (MODE == DROP_NEWEST) && tx_valid && tx_ready && w_full && !w_pop;
      rx_data  = rx_valid ? w_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         if (w_drop && (r_drop_cnt != DROP_CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
         end
      end
   end

   stream_link_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (w_push),
      .waddr (r_wptr),
      .wdata (tx_data),
      .raddr (r_rptr),
      .rdata (w_rdata)
   );

   assign level    = r_level;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_stream_link_fifo.sv
// Bench for stream_link_fifo: one backpressure and one drop-newest instance
// (WIDTH=3, DEPTH=4) compared every cycle against a queue-style reference model.
module tb_stream_link_fifo;

   typedef logic [2:0] word_t;

   typedef struct {
      logic  rst;
      logic  v;
      word_t d;
      logic  rr;
      logic  etr;
      logic  erv;
      word_t ed;
      word_t el;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       a_valid, a_ready, b_valid, b_ready;
   word_t      a_data, b_data;
   logic       a_tx_ready, a_rx_valid, b_tx_ready, b_rx_valid;
   word_t      a_rx_data, b_rx_data;
   logic [2:0] a_level, b_level;
   logic [7:0] a_drop, b_drop;

   stream_link_fifo #(.WIDTH(3), .DEPTH(4), .DROP_MODE(0)) dut_bp (
      .clk(clk), .rst_n(rst_n),
      .tx_valid(a_valid), .tx_ready(a_tx_ready), .tx_data(a_data),
      .rx_valid(a_rx_valid), .rx_ready(a_ready), .rx_data(a_rx_data),
      .level(a_level), .drop_cnt(a_drop)
   );

   stream_link_fifo #(.WIDTH(3), .DEPTH(4), .DROP_MODE(1)) dut_dn (
      .clk(clk), .rst_n(rst_n),
      .tx_valid(b_valid), .tx_ready(b_tx_ready), .tx_data(b_data),
      .rx_valid(b_rx_valid), .rx_ready(b_ready), .rx_data(b_rx_data),
      .level(b_level), .drop_cnt(b_drop)
   );

   int n_err    = 0;
   int n_checks = 0;

   // Reference model: unbounded FIFO as a growing array with head/tail indices.
   word_t mstore [2][0:4095];
   int    hd    [2];
   int    tl    [2];
   int    drops [2];

   // Producer rule on the backpressure side: a refused word must be re-offered unchanged.
   logic  r_blk = 1'b0;
   word_t r_blk_data;
   always @(posedge clk) begin
      if (r_blk) begin
         assert (a_valid && (a_data == r_blk_data))
            else $error("producer rule broken on backpressure port");
      end
      r_blk      <= rst_n && a_valid && !a_tx_ready;
      r_blk_data <= a_data;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input int m, input logic tr, input logic rv, input word_t d,
                            input logic [2:0] lvl, input logic [7:0] dc);
      int    sz = tl[m] - hd[m];
      int    ed = (sz > 0) ? int'(mstore[m][hd[m]]) : 0;
      string p  = (m == 0) ? "bp" : "dn";
      check({p, "_tx_ready"}, int'(tr), (rst_n && (m == 1 || sz < 4)) ? 1 : 0);
      check({p, "_rx_valid"}, int'(rv), (sz > 0) ? 1 : 0);
      check({p, "_rx_data"},  int'(d),  ed);
      check({p, "_level"},    int'(lvl), sz);
      check({p, "_drop_cnt"}, int'(dc), drops[m]);
   endtask

   task automatic model_update(input int m, input logic v, input word_t d, input logic rr);
      int sz   = tl[m] - hd[m];
      bit full = (sz == 4);
      bit pop  = (sz > 0) && rr;
      bit acc;
      if (!rst_n) begin
         hd[m]    = tl[m];
         drops[m] = 0;
         return;
      end
      acc = v && (!full || (m == 1 && pop));
      if (m == 1 && v && full && !pop && drops[m] < 255) drops[m]++;
      if (pop) hd[m]++;
      if (acc) begin
         mstore[m][tl[m]] = d;
         tl[m]++;
      end
   endtask

   task automatic half_a();
      @(negedge clk);
      check_dut(0, a_tx_ready, a_rx_valid, a_rx_data, a_level, a_drop);
      check_dut(1, b_tx_ready, b_rx_valid, b_rx_data, b_level, b_drop);
   endtask

   task automatic half_b();
      @(posedge clk);
      model_update(0, a_valid, a_data, a_ready);
      model_update(1, b_valid, b_data, b_ready);
      #1;
   endtask

   task automatic tick();
      half_a();
      half_b();
   endtask

   task automatic push_b(input word_t x);
      b_valid = 1'b1; b_data = x; b_ready = 1'b0;
      tick();
      b_valid = 1'b0;
   endtask

   task automatic drain_b(input string name, input word_t e0, input word_t e1,
                          input word_t e2, input word_t e3);
      word_t exp [4];
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      b_valid = 1'b0; b_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         half_a();
         check(name, int'(b_rx_data), int'(exp[i]));
         half_b();
      end
      b_ready = 1'b0;
   endtask

   function automatic vec_t mk(input int rst, input int v, input int d, input int rr,
                               input int etr, input int erv, input int ed, input int el);
      vec_t r;
      r.rst = rst[0]; r.v = v[0]; r.d = d[2:0]; r.rr = rr[0];
      r.etr = etr[0]; r.erv = erv[0]; r.ed = ed[2:0]; r.el = el[2:0];
      return r;
   endfunction

   vec_t  tbl [11];
   word_t prev;
   logic  a_blk;
   int    thr;

   initial begin
      rst_n = 1'b0;
      a_valid = 1'b0; a_ready = 1'b0; a_data = '0;
      b_valid = 1'b0; b_ready = 1'b0; b_data = '0;
      a_blk = 1'b0;
      for (int m = 0; m < 2; m++) begin
         hd[m] = 0; tl[m] = 0; drops[m] = 0;
      end
      repeat (2) begin
         @(posedge clk);
         model_update(0, a_valid, a_data, a_ready);
         model_update(1, b_valid, b_data, b_ready);
      end
      #1;

      // Reset, fill 1..4, then drain in order (backpressure instance).
      tbl[0]  = mk(0, 0, 0, 0,  0, 0, 0, 0);
      tbl[1]  = mk(1, 1, 1, 0,  1, 0, 0, 0);
      tbl[2]  = mk(1, 1, 2, 0,  1, 1, 1, 1);
      tbl[3]  = mk(1, 1, 3, 0,  1, 1, 1, 2);
      tbl[4]  = mk(1, 1, 4, 0,  1, 1, 1, 3);
      tbl[5]  = mk(1, 0, 0, 0,  0, 1, 1, 4);
      tbl[6]  = mk(1, 0, 0, 1,  0, 1, 1, 4);
      tbl[7]  = mk(1, 0, 0, 1,  1, 1, 2, 3);
      tbl[8]  = mk(1, 0, 0, 1,  1, 1, 3, 2);
      tbl[9]  = mk(1, 0, 0, 1,  1, 1, 4, 1);
      tbl[10] = mk(1, 0, 0, 0,  1, 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         rst_n = tbl[i].rst; a_valid = tbl[i].v; a_data = tbl[i].d; a_ready = tbl[i].rr;
         half_a();
         check("tbl_tx_ready", int'(a_tx_ready), int'(tbl[i].etr));
         check("tbl_rx_valid", int'(a_rx_valid), int'(tbl[i].erv));
         check("tbl_rx_data",  int'(a_rx_data),  int'(tbl[i].ed));
         check("tbl_level",    int'(a_level),    int'(tbl[i].el));
         half_b();
      end

      // Latency: a word pushed at one edge is visible right after it; then wrap twice.
      a_valid = 1'b1; a_data = 3'd6; a_ready = 1'b0;
      tick();
      check("lat_rx_valid", int'(a_rx_valid), 1);
      check("lat_rx_data",  int'(a_rx_data),  6);
      prev = 3'd6;
      for (int i = 0; i < 10; i++) begin
         a_valid = 1'b1; a_data = word_t'(i + 1); a_ready = 1'b1;
         half_a();
         check("wrap_rx_data", int'(a_rx_data), int'(prev));
         check("wrap_level",   int'(a_level),   1);
         half_b();
         prev = word_t'(i + 1);
      end
      a_valid = 1'b0;
      tick();
      a_ready = 1'b0;
      check("wrap_empty", int'(a_level), 0);

      // Drop-newest: simultaneous push and pop while full.
      push_b(3'd5); push_b(3'd6); push_b(3'd7); push_b(3'd0);
      b_valid = 1'b1; b_data = 3'd3; b_ready = 1'b1;
      half_a();
      check("full_pp_rx_data", int'(b_rx_data), 5);
      half_b();
      b_valid = 1'b0; b_ready = 1'b0;
      check("full_pp_level", int'(b_level), 4);
      drain_b("full_pp_order", 3'd6, 3'd7, 3'd0, 3'd3);
      check("full_pp_drop", int'(b_drop), 0);

      // Reset mid-operation with level 3 and two drops recorded.
      push_b(3'd1); push_b(3'd2); push_b(3'd3); push_b(3'd4);
      b_valid = 1'b1; b_data = 3'd7;
      tick(); tick();
      b_valid = 1'b0; b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      check("pre_rst_level", int'(b_level), 3);
      check("pre_rst_drop",  int'(b_drop),  2);
      rst_n = 1'b0;
      b_valid = 1'b1; b_data = 3'd5; b_ready = 1'b1;
      a_valid = 1'b1; a_data = 3'd2; a_ready = 1'b1;
      half_a();
      check("rst_tx_ready_dn", int'(b_tx_ready), 0);
      check("rst_tx_ready_bp", int'(a_tx_ready), 0);
      half_b();
      rst_n = 1'b1;
      b_valid = 1'b0; b_ready = 1'b0; a_valid = 1'b0; a_ready = 1'b0;
      check("post_rst_level",    int'(b_level),    0);
      check("post_rst_drop",     int'(b_drop),     0);
      check("post_rst_rx_valid", int'(b_rx_valid), 0);
      check("post_rst_rx_data",  int'(b_rx_data),  0);
      check("post_rst_tx_ready", int'(b_tx_ready), 1);
      push_b(3'd1);
      check("post_rst_push_valid", int'(b_rx_valid), 1);
      check("post_rst_push_data",  int'(b_rx_data),  1);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;

      // Drop policy: 300 words offered into a full buffer.
      push_b(3'd1); push_b(3'd2); push_b(3'd3); push_b(3'd4);
      for (int i = 0; i < 300; i++) begin
         b_valid = 1'b1; b_data = word_t'($urandom); b_ready = 1'b0;
         half_a();
         check("drop_tx_ready", int'(b_tx_ready), 1);
         half_b();
      end
      b_valid = 1'b0;
      check("drop_sat",   int'(b_drop),  255);
      check("drop_level", int'(b_level), 4);
      drain_b("drop_contents", 3'd1, 3'd2, 3'd3, 3'd4);

      // Randomized traffic on both instances with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         thr   = (i < 750) ? 3 : 8;
         if (!a_blk) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_data  = word_t'($urandom);
         end
         a_ready = ($urandom_range(0, 9) < thr);
         b_valid = ($urandom_range(0, 3) != 0);
         b_data  = word_t'($urandom);
         b_ready = ($urandom_range(0, 9) < thr);
         half_a();
         a_blk = a_valid && !a_tx_ready;
         half_b();
      end
      rst_n = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
